// File: rtl/core5_cpu_4_dct_unpacker_pkg.sv
// core5_dct_pkg
// Shared widths and state encoding for the CPU 4 OCI data-trace unpacker.
//   SYM_W  - width of one trace symbol
//   SLOTS  - symbol slots per packed packet
//   BUF_W  - packed buffer width, derived from SYM_W*SLOTS
//   CNT_W  - width of the per-packet symbol count
package core5_dct_pkg;

   localparam int SYM_W = 2;
   localparam int SLOTS = 15;
   localparam int BUF_W = SYM_W * SLOTS;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } dct_state_e;

endpackage

// File: rtl/core5_cpu_4_dct_unpacker_if.sv
// core5_cpu_4_dct_unpacker_if
// Packet-in / symbol-out handshake bundle of the trace unpacker.
//   dct_buffer, dct_count, dct_valid, dct_ready - packed packet channel
//   sym_data, sym_valid, sym_ready, sym_last    - serial symbol channel
// slave  : the unpacker's view (consumes packets, produces symbols)
// master : the environment's view (produces packets, sinks symbols)
import core5_dct_pkg::*;

interface core5_cpu_4_dct_unpacker_if;

   logic [BUF_W-1:0] dct_buffer;
   logic [CNT_W-1:0] dct_count;
   logic             dct_valid;
   logic             dct_ready;
   logic [SYM_W-1:0] sym_data;
   logic             sym_valid;
   logic             sym_ready;
   logic             sym_last;

   modport slave (
      input  dct_buffer, dct_count, dct_valid, sym_ready,
      output dct_ready, sym_data, sym_valid, sym_last
   );

   modport master (
      output dct_buffer, dct_count, dct_valid, sym_ready,
      input  dct_ready, sym_data, sym_valid, sym_last
   );

endinterface

// File: rtl/core5_cpu_4_dct_unpacker.sv
// core5_cpu_4_dct_unpacker
// Replays packed OCI data-trace packets as a serial 2-bit symbol stream,
// LSB slot first, and reports drained once end-of-test is reached with no
// symbols left.
//   clk         - system clock, rising edge
//   reset_n     - asynchronous active-low reset
//   dct_if      - packet / symbol handshake bundle (slave modport)
//   test_ending - end-of-test request, sticky once seen
//   sym_total   - saturating count of symbol handshakes since reset
//   drained     - end-of-test reached and nothing pending
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a packet, dct_ready high unless ending
// ST_SHIFT | emitting symbols from shreg, remaining_q symbols left
// ST_DONE  | end of test reached and stream drained; held until reset
import core5_dct_pkg::*;

module core5_cpu_4_dct_unpacker #(
   parameter int TOT_W = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   core5_cpu_4_dct_unpacker_if.slave dct_if,
   input  logic                    test_ending,
   output logic [TOT_W-1:0]        sym_total,
   output logic                    drained
);

   dct_state_e        state_q, state_d;
   logic [BUF_W-1:0]  shreg_q, shreg_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic [TOT_W-1:0]  sym_total_q, sym_total_d;
   logic              ending_q, ending_d;

   logic ending_now;
   logic sym_valid;
   logic last_sym;
   logic sym_hs;
   logic dct_ready;
   logic load;

   // A request seen this cycle already blocks acceptance, so a packet offered
   // together with test_ending is never taken.
   assign ending_now = ending_q | test_ending;
   assign sym_valid  = (state_q == ST_SHIFT);
   assign last_sym   = (remaining_q == CNT_W'(1));
   assign sym_hs     = sym_valid & dct_if.sym_ready;

   // Reload in the same cycle the last symbol leaves, so packets stream
   // without a bubble; this makes dct_ready combinational from sym_ready.
   assign dct_ready  = !ending_now &&
                       ((state_q == ST_IDLE) || (sym_valid && last_sym && dct_if.sym_ready));
   assign load       = dct_if.dct_valid && dct_ready && (dct_if.dct_count != '0);

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      remaining_d = remaining_q;
      ending_d    = ending_now;
      sym_total_d = sym_total_q;

      if (sym_hs && !(&sym_total_q))
         sym_total_d = sym_total_q + TOT_W'(1);

      unique case (state_q)
         ST_IDLE: begin
            if (ending_now) begin
               state_d = ST_DONE;
            end else if (load) begin
               shreg_d     = dct_if.dct_buffer;
               remaining_d = dct_if.dct_count;
               state_d     = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (sym_hs) begin
               if (last_sym) begin
                  if (load) begin
                     shreg_d     = dct_if.dct_buffer;
                     remaining_d = dct_if.dct_count;
                  end else begin
                     shreg_d     = shreg_q >> SYM_W;
                     remaining_d = '0;
                     state_d     = ending_now ? ST_DONE : ST_IDLE;
                  end
               end else begin
                  shreg_d     = shreg_q >> SYM_W;
                  remaining_d = remaining_q - CNT_W'(1);
               end
            end
         end
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         remaining_q <= '0;
         sym_total_q <= '0;
         ending_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         remaining_q <= remaining_d;
         sym_total_q <= sym_total_d;
         ending_q    <= ending_d;
      end
   end

   assign dct_if.dct_ready = dct_ready;
   assign dct_if.sym_valid = sym_valid;
   assign dct_if.sym_data  = sym_valid ? shreg_q[SYM_W-1:0] : '0;
   assign dct_if.sym_last  = sym_valid & last_sym;
   assign sym_total        = sym_total_q;
   assign drained          = (state_q == ST_DONE);

endmodule

// File: doc/core5_cpu_4_dct_unpacker.md
# core5_cpu_4_dct_unpacker

Receive-side counterpart of the CPU 4 OCI data-trace compressor. It accepts packed trace packets (a 30-bit buffer holding up to 15 two-bit trace symbols plus a symbol count) and replays them as a serial symbol stream, one symbol per cycle, LSB first, under a valid/ready handshake. It sits between the OCI trace capture path and the trace sink or simulation checker. It also propagates the end-of-test condition as a drained indication once all accepted symbols have left.

## Interface
Parameters:
- SYM_W, 2, width of one trace symbol
- SLOTS, 15, symbol slots per packet; buffer width = SYM_W*SLOTS = 30 (derived, not overridable)
- CNT_W, 4, width of packet symbol count
- TOT_W, 16, width of emitted-symbol counter

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- dct_buffer  in  30  packed symbols; slot k at bits [2k+1:2k]
- dct_count  in  4  valid symbols in dct_buffer, 0..15
- dct_valid  in  1  packet offered
- dct_ready  out  1  packet accepted when dct_valid && dct_ready
- test_ending  in  1  end-of-test request, sampled each cycle
- sym_data  out  2  current symbol
- sym_valid  out  1  symbol offered
- sym_ready  in  1  sink accepts symbol
- sym_last  out  1  current symbol is the last of its packet
- sym_total  out  16  symbols handshaken since reset, saturating
- drained  out  1  end-of-test reached and no symbols pending

## Operation
- States: IDLE, SHIFT, DONE. Reset enters IDLE.
- IDLE: dct_ready=1, sym_valid=0.
  - Accept with dct_count=0: packet is discarded, state stays IDLE.
  - Accept with dct_count≠0: load shift register from dct_buffer, load remaining=dct_count, go to SHIFT.
- SHIFT: sym_valid=1, sym_data=shreg[1:0], sym_last=(remaining==1).
  - On sym_ready: shreg >>= 2 and remaining decrements.
  - When the last symbol handshakes: go to IDLE, or reload directly if a packet is accepted in the same cycle.
- Back-to-back: dct_ready = IDLE || (SHIFT && remaining==1 && sym_ready). This is a combinational path from sym_ready. No bubble between packets.
- test_ending: sets a sticky ending flag.
  - While ending is set, dct_ready=0.
  - The current packet in SHIFT finishes normally, then the block enters DONE instead of IDLE.
  - If ending is set in IDLE, the block goes to DONE on the next cycle.
- DONE: dct_ready=0, sym_valid=0, drained=1. The block stays in DONE until reset.
- sym_total increments on each sym_valid && sym_ready and holds at 0xFFFF.
- Backpressure: sym_data and sym_last hold stable while sym_valid && !sym_ready.

## Timing
- Reset values: state IDLE, sym_valid=0, sym_data=0, sym_last=0, sym_total=0, drained=0, ending flag 0; dct_ready=1 (combinational from IDLE).
- Latency: a packet accepted at edge N gives first symbol valid after edge N; an n-symbol packet needs n sink handshakes.
- Throughput: 1 symbol/cycle with sym_ready held high.
- test_ending and dct_valid in the same IDLE cycle: ending wins; dct_ready is already 0 in that cycle, so the packet is not accepted.
- reset_n asserted mid-packet: remaining symbols are lost and outputs return to reset values immediately (asynchronous).
- dct_count=15: all 30 bits are used. Slot bits above the count are ignored.

## Structure
- Package core5_dct_pkg holds SYM_W, SLOTS, CNT_W and the state enum (IDLE, SHIFT, DONE).
- Single module with no sub-module. The shift register, remaining counter and saturating counter are inline.

## Test plan
- Single packet: buffer=30'h1B, count=3, sym_ready=1 -> symbols 3,2,1 on consecutive cycles, sym_last on the third, sym_total=3.
- Backpressure: same packet with sym_ready toggled 1,0,0,1,1 -> sym_data holds at 2 during the low cycles; order 3,2,1 is unchanged.
- Back-to-back: count=2 then count=1 offered continuously -> 3 symbols on 3 consecutive cycles, no gap, sym_last on the 2nd and 3rd.
- Zero/full count: count=0 packet is accepted with no symbol output; count=15 with buffer=30'h3FFFFFFF -> 15 symbols of 3.
- End of test: test_ending pulsed during the 2nd symbol of a 4-symbol packet -> all 4 symbols emitted, dct_ready stays 0, drained=1 from the next cycle onward.
- Async reset mid-packet: reset_n low after 1 of 5 symbols -> sym_valid=0 at once, sym_total=0, dct_ready=1 after release.
